seg_scan_capture: RTL
=====================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 The block SHALL have the parameter STABLE_CYC, default 1, meaning consecutive identical samples required before a digit is accepted (range 1..15).
REQ-002 The block SHALL have the parameter DIGIT_MASK, default 8'b0000_0011, meaning the digit positions that must be captured to complete a frame.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have the port seg_com, input, 8 bits, active-low digit select; digit k is selected when only bit 7-k is 0 (8'b0111_1111 = digit 0 ones, 8'b1011_1111 = digit 1 tens).
REQ-006 The block SHALL have the port seg_data, input, 8 bits, active-high segments {a,b,c,d,e,f,g,dp} in bits [7:0].
REQ-007 The block SHALL have the port digits, output, 32 bits, the published BCD frame; nibble k holds digit k.
REQ-008 The block SHALL have the port sec_bin, output, 7 bits, digit1*10 + digit0 of the published frame (0..99).
REQ-009 The block SHALL have the port frame_stb, output, 1 bit, a one-cycle pulse when digits/sec_bin update.
REQ-010 The block SHALL have the port sec_chg, output, 1 bit, a one-cycle pulse coincident with frame_stb when the new sec_bin differs from the previous one.
REQ-011 The block SHALL have the port seg_err, output, 1 bit, a sticky flag for an illegal pattern or select.

Function
REQ-012 seg_com and seg_data SHALL be registered once (sample edge E1); all decoding uses the registered copies.
REQ-013 Segment decode with dp masked SHALL be: FC=0, 60=1, DA=2, F2=3, 66=4, B6=5, BE=6, E0=7, FE=8, F6=9; every other value is illegal.
REQ-014 A run counter SHALL count consecutive cycles with an unchanged registered {seg_com, seg_data}, saturating at 15, and restart at 1 on any change.
REQ-015 A sample SHALL be accepted exactly once per run, at the edge after the run count reaches STABLE_CYC; a held input is never re-accepted.
REQ-016 An accepted sample with seg_com 8'hFF (blank) SHALL be ignored without error.
REQ-017 An accepted sample with more than one low bit in seg_com SHALL set seg_err and store nothing.
REQ-018 An accepted sample with a legal select and an illegal pattern SHALL set seg_err; neither the shadow digit nor its seen bit changes.
REQ-019 An accepted legal sample SHALL write the shadow nibble k and set seen[k]; rewriting an already-seen digit overwrites the value.
REQ-020 When (seen | new bit) & DIGIT_MASK == DIGIT_MASK, at that same edge (E2) the block SHALL copy shadow into digits including the new nibble, update sec_bin, pulse frame_stb, and clear seen to 0.
REQ-021 Latency SHALL be 2 cycles with STABLE_CYC=1: the final required digit present on the inputs before edge E1 gives frame_stb high after E2.
REQ-022 Digits outside DIGIT_MASK SHALL still be captured into shadow and published with the next frame.
REQ-023 sec_bin SHALL be computed from the nibbles being published, not from stale outputs.
REQ-024 The first frame after reset SHALL always assert sec_chg.
REQ-025 seg_err SHALL be cleared only by reset.

Reset
REQ-026 While rst=0: digits=0, sec_bin=0, frame_stb=0, sec_chg=0, seg_err=0, seen=0, shadow=0, input registers = 8'hFF/8'h00, run count=0, first-frame flag set.
REQ-027 Reset asserted mid-frame SHALL discard partial captures; after release, a frame requires every DIGIT_MASK digit again.

Verification
REQ-028 Alternate seg_com 7F/BF each cycle with data B6 (5) and F6 (9) -> frame_stb every 2 cycles, digits[7:0]=8'h95, sec_bin=95, sec_chg only on the first frame.
REQ-029 Step the ones digit 60->DA with tens fixed at FC -> sec_bin 1 then 2, sec_chg pulses exactly at each change.
REQ-030 Digit 0 with data 8'h01 (illegal) -> seg_err=1 and held, no frame_stb until a legal digit 0 arrives; digits unchanged.
REQ-031 seg_com=8'h3F -> seg_err=1; seg_com=8'hFF for 20 cycles -> no error and no frame.
REQ-032 With STABLE_CYC=3: each digit held 2 cycles -> no frame; each held 3 cycles -> frame; a 10-cycle hold is accepted once.
REQ-033 Capture digit 0 only, pulse rst low, then send digit 1 only -> no frame_stb; outputs are 0 after reset.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Purpose: samples a multiplexed 7-segment scan bus, debounces it, and assembles the BCD digits into frames.
// Latency: a frame is published 2 cycles after the last required digit appears (STABLE_CYC=1), or STABLE_CYC+1 cycles in general.
// Backpressure: none; this is a free-running sampler and each frame is a one-cycle strobe.
module seg_scan_capture #(
    parameter int unsigned STABLE_CYC = 1,
    parameter logic [7:0]  DIGIT_MASK = 8'b0000_0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_com,
    input  logic [7:0]  seg_data,
    output logic [31:0] digits,
    output logic [6:0]  sec_bin,
    output logic        frame_stb,
    output logic        sec_chg,
    output logic        seg_err
);

    localparam logic [3:0] STABLE_Q = 4'(STABLE_CYC);

    logic [7:0]  com_q;
    logic [7:0]  dat_q;
    logic [3:0]  run_cnt;
    logic        taken;
    logic [7:0]  seen;
    logic [31:0] shadow;
    logic        first;

    logic        chg_in;
    logic        accept;
    logic        blank;
    logic        onehot;
    logic [7:0]  sel_inv;
    logic [2:0]  sel_k;
    logic [3:0]  seg_val;
    logic        seg_legal;
    logic [31:0] shadow_upd;
    logic [7:0]  seen_upd;
    logic        complete;
    logic [6:0]  new_sec;
    logic        write_ok;
    logic        bad;

    // Decide whether the registered sample is stable and still unconsumed.
    always_comb begin
        chg_in = {seg_com, seg_data} != {com_q, dat_q};
        accept = (run_cnt >= STABLE_Q) && (run_cnt != 4'd0) && !taken;
    end

    // Classify the select: blank, exactly one digit, or illegal; find digit index.
    always_comb begin
        sel_inv = ~com_q;
        blank   = (com_q == 8'hFF);
        onehot  = !blank && ((sel_inv & (sel_inv - 8'd1)) == 8'd0);
        sel_k   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!com_q[7-i]) sel_k = 3'(i);
        end
    end

    // Segment pattern to BCD, decimal point ignored.
    always_comb begin
        seg_val   = 4'd0;
        seg_legal = 1'b1;
        case (dat_q & 8'hFE)
            8'hFC:   seg_val = 4'd0;
            8'h60:   seg_val = 4'd1;
            8'hDA:   seg_val = 4'd2;
            8'hF2:   seg_val = 4'd3;
            8'h66:   seg_val = 4'd4;
            8'hB6:   seg_val = 4'd5;
            8'hBE:   seg_val = 4'd6;
            8'hE0:   seg_val = 4'd7;
            8'hFE:   seg_val = 4'd8;
            8'hF6:   seg_val = 4'd9;
            default: seg_legal = 1'b0;
        endcase
    end

    // Prospective shadow/seen after this sample, and frame completion using the new nibble.
    always_comb begin
        shadow_upd                     = shadow;
        shadow_upd[{sel_k, 2'b00} +: 4] = seg_val;
        seen_upd                       = seen | (8'd1 << sel_k);
        complete                       = ((seen_upd & DIGIT_MASK) == DIGIT_MASK);
        new_sec                        = 7'(shadow_upd[7:4]) * 7'd10 + 7'(shadow_upd[3:0]);
        write_ok                       = accept && onehot && seg_legal;
        bad                            = accept && !blank && (!onehot || !seg_legal);
    end

    // Input sample registers plus run-length tracking for debounce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            com_q   <= 8'hFF;
            dat_q   <= 8'h00;
            run_cnt <= 4'd0;
            taken   <= 1'b0;
        end else begin
            com_q <= seg_com;
            dat_q <= seg_data;
            if (chg_in) begin
                run_cnt <= 4'd1;
                taken   <= 1'b0;
            end else begin
                if (run_cnt != 4'd15) run_cnt <= run_cnt + 4'd1;
                if (accept) taken <= 1'b1;
            end
        end
    end

    // Capture digits into the shadow and publish a frame once every required digit is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= 32'd0;
            seen      <= 8'd0;
            digits    <= 32'd0;
            sec_bin   <= 7'd0;
            frame_stb <= 1'b0;
            sec_chg   <= 1'b0;
            seg_err   <= 1'b0;
            first     <= 1'b1;
        end else begin
            frame_stb <= 1'b0;
            sec_chg   <= 1'b0;
            if (bad) seg_err <= 1'b1;
            if (write_ok) begin
                shadow <= shadow_upd;
                if (complete) begin
                    digits    <= shadow_upd;
                    sec_bin   <= new_sec;
                    frame_stb <= 1'b1;
                    sec_chg   <= first || (new_sec != sec_bin);
                    first     <= 1'b0;
                    seen      <= 8'd0;
                end else begin
                    seen <= seen_upd;
                end
            end
        end
    end

endmodule
